// File: rtl/uart_rx_cfg.sv
// UART receiver with configurable data width, parity mode and stop-bit count.
// It has a 2-FF input synchroniser, start-bit glitch rejection, and parity and framing error flags.
module uart_rx_cfg #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 Rx_Active,
    output logic                 Rx_Done,
    output logic                 parity_err,
    output logic                 frame_err
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] MidCnt = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] EndCnt = CntW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] LastData = 4'(DATA_BITS - 1);
    localparam logic [3:0] LastStop = 4'(STOP_BITS - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StStart = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StPar   = 3'd3;
    localparam logic [2:0] StStop  = 3'd4;
    localparam logic [2:0] StDone  = 3'd5;

    logic                 rx_meta_q, rx_s_q;
    logic [2:0]           state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 load;
    logic                 tick;

    assign tick = (cnt_q == EndCnt);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        load    = 1'b0;
        case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    state_d = StStart;
                    cnt_d   = '0;
                    bit_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            StStart: begin
                if (cnt_q == MidCnt) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (tick) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    if (bit_q == LastData) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? StPar : StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPar: begin
                if (tick) begin
                    cnt_d   = '0;
                    perr_d  = (PARITY == 1) ? ~^{shift_q, rx_s_q} : ^{shift_q, rx_s_q};
                    state_d = StStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (tick) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        ferr_d = 1'b1;
                    end
                    // Leave at the last mid-stop sample so a following start edge is not missed.
                    if (bit_q == LastStop) begin
                        state_d = StDone;
                        load    = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_out   <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta_q <= serial_in;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            // Results are loaded on entry to DONE so they are valid alongside the strobe.
            if (load) begin
                data_out   <= shift_q;
                parity_err <= perr_q;
                frame_err  <= ferr_d;
            end
        end
    end

    assign Rx_Active = (state_q == StStart) || (state_q == StData) ||
                       (state_q == StPar) || (state_q == StStop);
    assign Rx_Done   = (state_q == StDone);

endmodule
